// File: rtl/nco2_sincos.sv
// rtl/nco2_sincos.sv - quadrature NCO: 32-bit phase accumulator feeding a pipelined CORDIC rotator
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset; clears accumulator, pipeline and valid chain
//   clken      clock enable; when low every register holds
//   phi_inc_i  unsigned phase increment per enabled cycle (f_out = f_clk*phi_inc_i/2^PHASE_W)
//   fsin_o     signed sine sample, range [-2047,+2047]
//   fcos_o     signed cosine sample, range [-2047,+2047]
//   out_valid  high once the phase-0 sample reaches the outputs; stays high until reset
module nco2_sincos #(
    parameter int PHASE_W     = 32,
    parameter int OUT_W       = 12,
    parameter int CORDIC_ITER = 14,
    parameter int INT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic [PHASE_W-1:0]      phi_inc_i,
    output logic signed [OUT_W-1:0] fsin_o,
    output logic signed [OUT_W-1:0] fcos_o,
    output logic                    out_valid
);

    localparam int LATENCY = CORDIC_ITER + 2;
    // One bit below INT_W is kept free so the CORDIC gain plus rounding
    // drift can never overflow the x/y registers.
    localparam int GUARD = INT_W - OUT_W - 1;
    localparam int RND_W = INT_W - GUARD;
    // Angle datapath in units of 2^-20 turn; the arctan table below is in these units.
    localparam int Z_W = 20;
    // round((2^(OUT_W-1)-1)/1.646760): start magnitude pre-divided by the CORDIC gain.
    localparam int X_INIT_LSB = 1243;
    localparam logic signed [INT_W-1:0] X_INIT   = INT_W'(X_INIT_LSB * (2 ** GUARD));
    localparam logic signed [INT_W-1:0] OUT_HALF = INT_W'(2 ** (GUARD - 1));
    localparam logic signed [RND_W-1:0] LIM      = RND_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [OUT_W-1:0] OUT_MAX  = OUT_W'(2 ** (OUT_W - 1) - 1);

    // atan(2^-i) expressed in 2^-20 turn
    function automatic logic signed [Z_W-1:0] atan_z(input int i);
        case (i)
            0:       atan_z = 20'sd131072;
            1:       atan_z = 20'sd77376;
            2:       atan_z = 20'sd40884;
            3:       atan_z = 20'sd20753;
            4:       atan_z = 20'sd10417;
            5:       atan_z = 20'sd5213;
            6:       atan_z = 20'sd2607;
            7:       atan_z = 20'sd1304;
            8:       atan_z = 20'sd652;
            9:       atan_z = 20'sd326;
            10:      atan_z = 20'sd163;
            11:      atan_z = 20'sd81;
            12:      atan_z = 20'sd41;
            13:      atan_z = 20'sd20;
            default: atan_z = '0;
        endcase
    endfunction

    // Rounding offset for an arithmetic shift by i, so the shifts do not bias the vector.
    function automatic logic signed [INT_W-1:0] half_lsb(input int i);
        half_lsb = (i == 0) ? '0 : INT_W'(1) << (i - 1);
    endfunction

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [RND_W-1:0] v);
        if (v > LIM)
            sat = OUT_MAX;
        else if (v < -LIM)
            sat = -OUT_MAX;
        else
            sat = OUT_W'(v);
    endfunction

    logic [PHASE_W-1:0]      acc;
    logic [15:0]             ang;
    logic signed [INT_W-1:0] x_r  [0:CORDIC_ITER];
    logic signed [INT_W-1:0] y_r  [0:CORDIC_ITER];
    logic signed [Z_W-1:0]   z_r  [0:CORDIC_ITER-1];
    logic [1:0]              q_r  [0:CORDIC_ITER];
    logic signed [INT_W-1:0] x_sh [0:CORDIC_ITER-1];
    logic signed [INT_W-1:0] y_sh [0:CORDIC_ITER-1];
    logic [LATENCY-2:0]      vld_r;

    logic signed [INT_W-1:0] x_sum;
    logic signed [INT_W-1:0] y_sum;
    logic signed [RND_W-1:0] rx;
    logic signed [RND_W-1:0] ry;
    logic signed [RND_W-1:0] sin_q;
    logic signed [RND_W-1:0] cos_q;

    assign ang = acc[PHASE_W-1 -: 16];

    always_comb begin
        for (int i = 0; i < CORDIC_ITER; i++) begin
            x_sh[i] = (x_r[i] + half_lsb(i)) >>> i;
            y_sh[i] = (y_r[i] + half_lsb(i)) >>> i;
        end
    end

    // Round to output LSBs, then undo the quadrant fold by swapping/negating x and y.
    always_comb begin
        x_sum = x_r[CORDIC_ITER] + OUT_HALF;
        y_sum = y_r[CORDIC_ITER] + OUT_HALF;
        rx    = RND_W'(x_sum >>> GUARD);
        ry    = RND_W'(y_sum >>> GUARD);
        case (q_r[CORDIC_ITER])
            2'd0:    begin cos_q = rx;  sin_q = ry;  end
            2'd1:    begin cos_q = -ry; sin_q = rx;  end
            2'd2:    begin cos_q = -rx; sin_q = -ry; end
            default: begin cos_q = ry;  sin_q = -rx; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc       <= '0;
            vld_r     <= '0;
            fsin_o    <= '0;
            fcos_o    <= '0;
            out_valid <= 1'b0;
            for (int s = 0; s <= CORDIC_ITER; s++) begin
                x_r[s] <= '0;
                y_r[s] <= '0;
                q_r[s] <= '0;
            end
            for (int s = 0; s < CORDIC_ITER; s++)
                z_r[s] <= '0;
        end else if (clken) begin
            acc   <= acc + phi_inc_i;
            vld_r <= {vld_r[LATENCY-3:0], 1'b1};

            // Stage 0 sees the pre-increment phase. When bit 13 is set the angle is
            // past 45 deg into its quadrant, so it is referred to the next quadrant
            // axis instead: the 14-bit residual read as signed is exactly that offset.
            x_r[0] <= X_INIT;
            y_r[0] <= '0;
            z_r[0] <= {{2{ang[13]}}, ang[13:0], 4'b0000};
            q_r[0] <= ang[15:14] + {1'b0, ang[13]};

            for (int i = 0; i < CORDIC_ITER; i++) begin
                if (z_r[i][Z_W-1]) begin
                    x_r[i+1] <= x_r[i] + y_sh[i];
                    y_r[i+1] <= y_r[i] - x_sh[i];
                end else begin
                    x_r[i+1] <= x_r[i] - y_sh[i];
                    y_r[i+1] <= y_r[i] + x_sh[i];
                end
                q_r[i+1] <= q_r[i];
            end
            for (int i = 0; i < CORDIC_ITER - 1; i++) begin
                if (z_r[i][Z_W-1])
                    z_r[i+1] <= z_r[i] + atan_z(i);
                else
                    z_r[i+1] <= z_r[i] - atan_z(i);
            end

            fsin_o    <= sat(sin_q);
            fcos_o    <= sat(cos_q);
            out_valid <= vld_r[LATENCY-2];
        end
    end

endmodule

// File: tb/tb_nco2_sincos.sv
// tb/tb_nco2_sincos.sv - scoreboard testbench for nco2_sincos
module tb_nco2_sincos;

    localparam int LATENCY = 16;
    localparam int TOL     = 3;

    logic               clk       = 1'b0;
    logic               reset_n   = 1'b0;
    logic               clken     = 1'b0;
    logic [31:0]        phi_inc_i = '0;
    logic signed [11:0] fsin_o;
    logic signed [11:0] fcos_o;
    logic               out_valid;

    nco2_sincos dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .phi_inc_i (phi_inc_i),
        .fsin_o    (fsin_o),
        .fcos_o    (fcos_o),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] phase;
        int          s;
        int          c;
    } exp_t;

    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pop   = 0;
    logic [31:0] m_acc   = '0;

    // round(2047*sin(k*22.5 deg)), k = 0..15
    int sin16 [16] = '{0, 783, 1447, 1891, 2047, 1891, 1447, 783,
                       0, -783, -1447, -1891, -2047, -1891, -1447, -783};

    task automatic check(input string name, input longint act, input longint exp, input int tol);
        n_tests++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    function automatic int rnd(input real r);
        if (r >= 0.0)
            return $rtoi(r + 0.5);
        else
            return -$rtoi(-r + 0.5);
    endfunction

    // Multiples of 22.5 deg come from the hand table; any other phase from the ideal formula.
    function automatic void expected(input logic [31:0] ph, output int s, output int c);
        real a;
        int  k;
        if (ph[27:0] == 28'd0) begin
            k = int'(ph[31:28]);
            s = sin16[k];
            c = sin16[(k + 4) % 16];
        end else begin
            a = 2.0 * 3.14159265358979 * real'(ph) / 4294967296.0;
            s = rnd(2047.0 * $sin(a));
            c = rnd(2047.0 * $cos(a));
        end
    endfunction

    // One clock of stimulus, applied on the falling edge; enabled cycles push the expected sample.
    task automatic step(input logic rn, input logic en, input logic [31:0] inc);
        exp_t e;
        int   s;
        int   c;
        @(negedge clk);
        reset_n   = rn;
        clken     = en;
        phi_inc_i = inc;
        if (!rn) begin
            sb.delete();
            m_acc = '0;
        end else if (en) begin
            expected(m_acc, s, c);
            e.phase = m_acc;
            e.s     = s;
            e.c     = c;
            sb.push_back(e);
            m_acc = m_acc + inc;
        end
    endtask

    logic               mon_rn;
    logic               mon_en;
    int                 en_cnt = 0;
    logic               prev_v = 1'b0;
    logic signed [11:0] prev_s = '0;
    logic signed [11:0] prev_c = '0;
    exp_t               me;
    longint             ls;
    longint             lc;

    always @(posedge clk) begin
        mon_rn = reset_n;
        mon_en = clken;
        #1;
        if (!mon_rn) begin
            check("reset_valid", out_valid, 0, 0);
            check("reset_sin", fsin_o, 0, 0);
            check("reset_cos", fcos_o, 0, 0);
            en_cnt = 0;
        end else if (mon_en) begin
            if (en_cnt < LATENCY)
                en_cnt++;
            if (en_cnt < LATENCY) begin
                check($sformatf("fill_valid edge=%0d", en_cnt), out_valid, 0, 0);
                check($sformatf("fill_sin edge=%0d", en_cnt), fsin_o, 0, 0);
                check($sformatf("fill_cos edge=%0d", en_cnt), fcos_o, 0, 0);
            end else begin
                check("valid_high", out_valid, 1, 0);
                if (sb.size() == 0) begin
                    check("scoreboard_nonempty", 0, 1, 0);
                end else begin
                    me = sb.pop_front();
                    n_pop++;
                    ls = fsin_o;
                    lc = fcos_o;
                    check($sformatf("sin ph=%08h", me.phase), ls, me.s, TOL);
                    check($sformatf("cos ph=%08h", me.phase), lc, me.c, TOL);
                    check("sin_not_-2048", (ls == -2048) ? 1 : 0, 0, 0);
                    check("cos_not_-2048", (lc == -2048) ? 1 : 0, 0, 0);
                    check($sformatf("magnitude ph=%08h", me.phase), ls * ls + lc * lc, 4190209, 41902);
                end
            end
        end else begin
            check("hold_valid", out_valid, prev_v, 0);
            check("hold_sin", fsin_o, prev_s, 0);
            check("hold_cos", fcos_o, prev_c, 0);
        end
        prev_v = out_valid;
        prev_s = fsin_o;
        prev_c = fcos_o;
    end

    initial begin
        logic [31:0] inc;
        int          sweep_n;

        // Reset held 7 cycles with clken toggling, then fill at 5/16 f_clk.
        for (int i = 0; i < 7; i++)
            step(1'b0, i[0], 32'h5000_0000);
        repeat (48) step(1'b1, 1'b1, 32'h5000_0000);

        // Cardinal phases.
        repeat (24) step(1'b1, 1'b1, 32'h4000_0000);

        // Enable gating mid-stream.
        repeat (5) step(1'b1, 1'b0, 32'h4000_0000);
        repeat (12) step(1'b1, 1'b1, 32'h4000_0000);

        // Increment change to 22.5 deg per sample, then a one-cycle reset.
        repeat (24) step(1'b1, 1'b1, 32'h1000_0000);
        step(1'b0, 1'b1, 32'h1000_0000);
        repeat (6) step(1'b1, 1'b1, 32'h1000_0000);
        repeat (3) step(1'b1, 1'b0, 32'h1000_0000);
        repeat (24) step(1'b1, 1'b1, 32'h1000_0000);

        // Random-increment sweep with occasional stalls.
        inc     = $urandom;
        sweep_n = 0;
        while (sweep_n < 10000) begin
            if (sweep_n % 64 == 0)
                inc = $urandom;
            if ($urandom_range(0, 9) != 0) begin
                step(1'b1, 1'b1, inc);
                sweep_n++;
            end else begin
                step(1'b1, 1'b0, inc);
            end
        end
        repeat (20) step(1'b1, 1'b1, inc);
        @(negedge clk);

        check("in_flight_samples", sb.size(), LATENCY - 1, 0);
        check("samples_checked", (n_pop >= 10000) ? 1 : 0, 1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
